rom_dl_writer: RTL and testbench

- Bridge between the data_io download stream and port 1 (ROM upload port) of the sdram controller.
- Packs the byte-wide ioctl writes into 16-bit word writes with correct byte strobes and buffers them in a small FIFO.
- Drives the sdram toggle-style req/ack handshake.
- Raises rom_loaded once every downloaded byte has been acknowledged by the sdram. This replaces the ad-hoc req toggling and rom_loaded logic in the core top level.

---
 rtl/rom_dl_writer_if.sv | 12 +
 rtl/rom_dl_writer.sv | 172 +++++++++++++++++
 tb/tb_rom_dl_writer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_dl_writer_if.sv
// Port-1 (ROM upload) side of the sdram controller: toggle req/ack plus word address, strobes, data.
interface rom_dl_writer_if;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port1_we;

  modport master (output port1_req, port1_a, port1_ds, port1_d, port1_we, input port1_ack);
  modport slave  (input port1_req, port1_a, port1_ds, port1_d, port1_we, output port1_ack);
endinterface

// File: rtl/rom_dl_writer.sv
// Packs ioctl download bytes into 16-bit sdram port-1 writes; wr->req toggle 3 cycles later.
// Backpressure: FIFO_DEPTH-entry write FIFO, pushes into a full FIFO are dropped and flag overflow.
module rom_dl_writer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DL_INDEX   = 8'd0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  rom_dl_writer_if.master        port1,
  output logic                   rom_loaded,
  output logic                   overflow
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic          act_q, act_d, act_dly_q;
  logic          pend_vld_q, pend_vld_d;
  logic [24:1]   pend_addr_q, pend_addr_d;
  logic [7:0]    pend_dat_q, pend_dat_d;
  logic          push_vld_q, push_vld_d;
  wr_t           push_q, push_d;
  wr_t           fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          req_q, req_d;
  wr_t           out_q, out_d;
  logic          loaded_q, loaded_d, ovf_q, ovf_d, accepted_q;
  logic          act_rise, act_fall, pv, fifo_full, fifo_empty, fifo_wr, pop, done_now;

  assign act_d      = ioctl_download && (ioctl_index == DL_INDEX);
  assign act_rise   = act_q && !act_dly_q;
  assign act_fall   = !act_q && act_dly_q;
  assign pv         = pend_vld_q && !act_rise;
  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign fifo_wr    = push_vld_q && !fifo_full;

  // Byte merge: decide this cycle, push lands in the FIFO next cycle.
  always_comb begin
    push_vld_d  = 1'b0;
    push_d      = '0;
    pend_vld_d  = pv;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;
    if (ioctl_wr && act_q) begin
      if (!ioctl_addr[0]) begin
        if (pv) begin
          push_vld_d = 1'b1;
          push_d     = '{a: pend_addr_q[23:1], ds: 2'b01, d: {pend_dat_q, pend_dat_q}};
        end
        pend_vld_d  = 1'b1;
        pend_addr_d = ioctl_addr[24:1];
        pend_dat_d  = ioctl_dout;
      end else if (pv && (pend_addr_q == ioctl_addr[24:1])) begin
        push_vld_d = 1'b1;
        push_d     = '{a: ioctl_addr[23:1], ds: 2'b11, d: {ioctl_dout, pend_dat_q}};
        pend_vld_d = 1'b0;
      end else begin
        push_vld_d = 1'b1;
        push_d     = '{a: ioctl_addr[23:1], ds: 2'b10, d: {ioctl_dout, ioctl_dout}};
      end
    end else if (act_fall && pend_vld_q) begin
      push_vld_d = 1'b1;
      push_d     = '{a: pend_addr_q[23:1], ds: 2'b01, d: {pend_dat_q, pend_dat_q}};
      pend_vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    req_d   = req_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        out_d   = fifo_q[rptr_q];
        state_d = ISSUE;
      end
      ISSUE: begin
        req_d   = !req_q;
        state_d = WAIT;
      end
      WAIT: if (port1.port1_ack == req_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cnt_d = cnt_q + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, pop};

  // Everything written and acknowledged; a simultaneous rise of act is excluded by !act_q.
  assign done_now = !act_q && !pend_vld_q && fifo_empty && (state_q == IDLE) &&
                    !push_vld_q && accepted_q;

  always_comb begin
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    if (act_rise) begin
      loaded_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (done_now) loaded_d = 1'b1;
      if (push_vld_q && fifo_full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (fifo_wr) fifo_q[wptr_q] <= push_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      act_q       <= 1'b0;
      act_dly_q   <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
      push_vld_q  <= 1'b0;
      push_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      req_q       <= port1.port1_ack;
      out_q       <= '0;
      loaded_q    <= 1'b0;
      ovf_q       <= 1'b0;
      accepted_q  <= 1'b0;
    end else begin
      act_q       <= act_d;
      act_dly_q   <= act_q;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_dat_q  <= pend_dat_d;
      push_vld_q  <= push_vld_d;
      push_q      <= push_d;
      if (fifo_wr) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      req_q       <= req_d;
      out_q       <= out_d;
      loaded_q    <= loaded_d;
      ovf_q       <= ovf_d;
      accepted_q  <= accepted_q || act_rise;
    end
  end

  assign port1.port1_req = req_q;
  assign port1.port1_a   = out_q.a;
  assign port1.port1_ds  = out_q.ds;
  assign port1.port1_d   = out_q.d;
  assign port1.port1_we  = act_q || !fifo_empty || (state_q != IDLE) || push_vld_q ||
                           (act_fall && pend_vld_q);
  assign rom_loaded      = loaded_q || done_now;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_rom_dl_writer.sv
// Bench for rom_dl_writer: sdram ack model, write monitor and a byte-level merge reference.
module tb_rom_dl_writer;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        rom_loaded, overflow;
  logic        ack_r = 1'b0;

  rom_dl_writer_if p1 ();
  assign p1.port1_ack = ack_r;

  rom_dl_writer #(.FIFO_DEPTH(4), .DL_INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .port1(p1), .rom_loaded(rom_loaded), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk_sys) cyc++;

  // Monitor and sdram model: log each req toggle, answer it after 5 cycles when enabled.
  logic [40:0] obs_q[$];
  int          obs_cyc[$];
  logic        req_prev = 1'b0;
  int          we_cnt = 0, dly = 0;
  bit          ack_en = 1'b1, stale_req = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) req_prev = p1.port1_req;
    else if (p1.port1_req !== req_prev) begin
      obs_q.push_back({p1.port1_a, p1.port1_ds, p1.port1_d});
      obs_cyc.push_back(cyc);
      req_prev = p1.port1_req;
    end
    if (p1.port1_we === 1'b1) we_cnt++;
    if (stale_req) begin
      ack_r = ~ack_r;
      stale_req = 1'b0;
    end else if (ack_en && (p1.port1_req !== ack_r)) begin
      dly++;
      if (dly >= 5) begin
        ack_r = p1.port1_req;
        dly = 0;
      end
    end else dly = 0;
  end

  logic [24:0] b_addr[$];
  logic [7:0]  b_dat[$];
  logic [40:0] exp_q[$];
  int          drv_cyc[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the pairing rules to the whole byte list, flush at the end.
  task automatic build_exp();
    bit          pv = 0;
    logic [24:0] pa = '0;
    logic [7:0]  pd = '0;
    exp_q.delete();
    foreach (b_addr[i]) begin
      if (b_addr[i][0] == 1'b0) begin
        if (pv) exp_q.push_back({pa[23:1], 2'b01, pd, pd});
        pv = 1; pa = b_addr[i]; pd = b_dat[i];
      end else if (pv && (pa >> 1) == (b_addr[i] >> 1)) begin
        exp_q.push_back({b_addr[i][23:1], 2'b11, b_dat[i], pd});
        pv = 0;
      end else begin
        exp_q.push_back({b_addr[i][23:1], 2'b10, b_dat[i], b_dat[i]});
      end
    end
    if (pv) exp_q.push_back({pa[23:1], 2'b01, pd, pd});
  endtask

  task automatic drive_bytes(input logic [7:0] idx, input int gmin, input int gmax);
    drv_cyc.delete();
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick(2);
    foreach (b_addr[i]) begin
      ioctl_wr = 1'b1;
      ioctl_addr = b_addr[i];
      ioctl_dout = b_dat[i];
      drv_cyc.push_back(cyc);
      tick(1);
      ioctl_wr = 1'b0;
      tick($urandom_range(gmax, gmin));
    end
    ioctl_download = 1'b0;
  endtask

  task automatic wait_loaded(input string tag);
    bit ok = 0, we_bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (p1.port1_we === rom_loaded) we_bad = 1;
      if (rom_loaded === 1'b1) begin ok = 1; break; end
      tick(1);
    end
    check({tag, "_loaded"}, 64'(ok), 64'd1);
    check({tag, "_we_vs_loaded"}, 64'(we_bad), 64'd0);
    check({tag, "_req_acked"}, 64'(p1.port1_req), 64'(ack_r));
  endtask

  task automatic compare_writes(input string tag, input int base, input int n);
    check({tag, "_count"}, 64'(obs_q.size() - base), 64'(n));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 64'(obs_q[base + i]), 64'(exp_q[i]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    int base, lat, n;
    logic [24:0] a0;

    tick(1);
    reset = 1'b1;
    tick(3);
    check("rst_req_eq_ack", 64'(p1.port1_req), 64'(ack_r));
    check("rst_we", 64'(p1.port1_we), 64'd0);
    check("rst_a", 64'(p1.port1_a), 64'd0);
    check("rst_ds", 64'(p1.port1_ds), 64'd0);
    check("rst_d", 64'(p1.port1_d), 64'd0);
    check("rst_loaded", 64'(rom_loaded), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    tick(2);

    // Byte pairing
    b_addr = '{25'd0, 25'd1, 25'd2, 25'd3};
    b_dat  = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_exp();
    base = obs_q.size();
    drive_bytes(8'd0, 1, 1);
    wait_loaded("pair");
    compare_writes("pair", base, 2);
    check("pair_first_const", 64'(obs_q[base]), 64'({23'd0, 2'b11, 16'h2211}));
    lat = obs_cyc[base] - drv_cyc[1];
    check("pair_latency", 64'((lat >= 3) && (lat <= 4)), 64'd1);
    tick(3);

    // Odd-length tail
    b_addr = '{25'd0, 25'd1, 25'd2};
    b_dat  = '{8'hAA, 8'hBB, 8'hCC};
    build_exp();
    base = obs_q.size();
    drive_bytes(8'd0, 1, 2);
    wait_loaded("tail");
    compare_writes("tail", base, 2);
    check("tail_last_const", 64'(obs_q[base + 1]), 64'({23'd1, 2'b01, 16'hCCCC}));
    tick(3);

    // Non-sequential pairing
    b_addr = '{25'd4, 25'd7};
    b_dat  = '{8'h55, 8'h66};
    build_exp();
    base = obs_q.size();
    drive_bytes(8'd0, 1, 1);
    wait_loaded("nonseq");
    compare_writes("nonseq", base, 2);
    check("nonseq_first_const", 64'(obs_q[base]), 64'({23'd3, 2'b10, 16'h6666}));
    tick(3);

    // Index filter
    b_addr = '{25'd8, 25'd9, 25'd10};
    b_dat  = '{8'h01, 8'h02, 8'h03};
    base = obs_q.size();
    n = we_cnt;
    drive_bytes(8'd1, 1, 1);
    tick(20);
    check("filter_no_toggle", 64'(obs_q.size() - base), 64'd0);
    check("filter_we_low", 64'(we_cnt - n), 64'd0);
    check("filter_loaded_kept", 64'(rom_loaded), 64'd1);

    // Backpressure: ack held while 12 bytes stream at one per cycle
    b_addr.delete(); b_dat.delete();
    for (int i = 0; i < 12; i++) begin
      b_addr.push_back(25'h100 + 25'(i));
      b_dat.push_back(8'($urandom));
    end
    build_exp();
    base = obs_q.size();
    ack_en = 0;
    drive_bytes(8'd0, 0, 0);
    tick(12);
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_inflight", 64'(obs_q.size() - base), 64'd1);
    ack_en = 1;
    wait_loaded("bp");
    tick(10);
    compare_writes("bp", base, 5);
    tick(3);

    // Reset during WAIT with two entries queued
    b_addr = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd4, 25'd5};
    b_dat  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    base = obs_q.size();
    ack_en = 0;
    drive_bytes(8'd0, 1, 1);
    tick(6);
    check("rmid_inflight", 64'(obs_q.size() - base), 64'd1);
    reset = 1'b1;
    tick(1);
    check("rmid_req_eq_ack", 64'(p1.port1_req), 64'(ack_r));
    check("rmid_we", 64'(p1.port1_we), 64'd0);
    check("rmid_loaded", 64'(rom_loaded), 64'd0);
    tick(1);
    reset = 1'b0;
    base = obs_q.size();
    stale_req = 1;
    tick(20);
    check("rmid_no_toggle", 64'(obs_q.size() - base), 64'd0);
    check("rmid_we_after", 64'(p1.port1_we), 64'd0);
    ack_en = 1;
    do_reset();

    // Randomised downloads, spaced so the FIFO never fills
    for (int r = 0; r < 5; r++) begin
      b_addr.delete(); b_dat.delete();
      n = $urandom_range(10, 3);
      a0 = 25'($urandom);
      for (int i = 0; i < n; i++) begin
        if (r[0]) b_addr.push_back(a0 + 25'(i));
        else      b_addr.push_back(a0 + 25'($urandom_range(7, 0)));
        b_dat.push_back(8'($urandom));
      end
      build_exp();
      base = obs_q.size();
      drive_bytes(8'd0, 8, 12);
      wait_loaded($sformatf("rnd%0d", r));
      compare_writes($sformatf("rnd%0d", r), base, exp_q.size());
      check($sformatf("rnd%0d_ovf", r), 64'(overflow), 64'd0);
      tick(3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
